// File: rtl/clock_countdown.sv
// BCD hh:mm:ss countdown timer with load/start/stop control and a done pulse at zero.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: restart from the last loaded value at zero.
//
// state | meaning
// IDLE  | value loaded, not started
// RUN   | counting down on each ena tick
// PAUSE | stopped mid-count, value held
// DONE  | count reached 00:00:00

module clock_countdown #(
    parameter logic [7:0] HH_MAX = 8'h99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] hh_in,
    input  logic [7:0] mm_in,
    input  logic [7:0] ss_in,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // Minutes/seconds digit pair: 00 borrows to 59.
    function automatic logic [7:0] dec_sexa(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = (v[7:4] == 4'd0) ? 4'd5 : v[7:4] - 4'd1;
        end else begin
            r[3:0] = v[3:0] - 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // Hours only decrement when nonzero, so the tens digit never underflows.
    function automatic logic [7:0] dec_hours(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = v[7:4] - 4'd1;
        end else begin
            r[3:0] = v[3:0] - 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    logic       load_valid;
    logic       count_zero;
    logic       last_tick;
    logic       ss_borrow;
    logic       mm_borrow;
    logic [7:0] ss_dec;
    logic [7:0] mm_dec;
    logic [7:0] hh_dec;
    logic       can_start;

    always_comb begin
        load_valid = (hh_in[3:0] <= 4'd9) && (hh_in[7:4] <= 4'd9) &&
                     (mm_in[3:0] <= 4'd9) && (mm_in[7:4] <= 4'd5) &&
                     (ss_in[3:0] <= 4'd9) && (ss_in[7:4] <= 4'd5) &&
                     (hh_in <= HH_MAX);
        count_zero = ({hh, mm, ss} == 24'h000000);
        last_tick  = ({hh, mm, ss} == 24'h000001);
        ss_borrow  = (ss == 8'h00);
        mm_borrow  = ss_borrow && (mm == 8'h00);
        ss_dec     = dec_sexa(ss);
        mm_dec     = ss_borrow ? dec_sexa(mm) : mm;
        hh_dec     = mm_borrow ? dec_hours(hh) : hh;
        can_start  = (state == IDLE) || (state == PAUSE);
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [7:0] reload_hh;
    logic [7:0] reload_mm;
    logic [7:0] reload_ss;
    logic       reload_zero;

    always_comb begin
        reload_zero = ({reload_hh, reload_mm, reload_ss} == 24'h000000);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_hh <= 8'h00;
            reload_mm <= 8'h00;
            reload_ss <= 8'h00;
`endif
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            // One action per cycle, in priority order load > start > stop > tick.
            if (load) begin
                if (load_valid) begin
                    hh      <= hh_in;
                    mm      <= mm_in;
                    ss      <= ss_in;
                    state   <= IDLE;
                    running <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_hh <= hh_in;
                    reload_mm <= mm_in;
                    reload_ss <= ss_in;
`endif
                end else begin
                    load_err <= 1'b1;
                end
            end else if (start) begin
                if (can_start) begin
                    if (count_zero) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
            end else if (stop) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            end else if (ena && (state == RUN) && !count_zero) begin
                hh <= hh_dec;
                mm <= mm_dec;
                ss <= ss_dec;
                if (last_tick) begin
                    done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (reload_zero) begin
                        state   <= DONE;
                        running <= 1'b0;
                    end else begin
                        hh <= reload_hh;
                        mm <= reload_mm;
                        ss <= reload_ss;
                    end
`else
                    state   <= DONE;
                    running <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_countdown.sv
// Directed testbench for clock_countdown (instance built with HH_MAX = 8'h12).
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN selects the auto-reload checks.

module tb_clock_countdown;

    logic       clk_sys = 1'b0;
    logic       rst_b   = 1'b0;
    logic       ena     = 1'b0;
    logic       load    = 1'b0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic [7:0] hh_in   = 8'h00;
    logic [7:0] mm_in   = 8'h00;
    logic [7:0] ss_in   = 8'h00;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       running;
    logic       done;
    logic       load_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    clock_countdown #(.HH_MAX(8'h12)) dut (
        .clk      (clk_sys),
        .reset    (rst_b),
        .ena      (ena),
        .load     (load),
        .hh_in    (hh_in),
        .mm_in    (mm_in),
        .ss_in    (ss_in),
        .start    (start),
        .stop     (stop),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .running  (running),
        .done     (done),
        .load_err (load_err)
    );

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load  = 1'b1;
        hh_in = h;
        mm_in = m;
        ss_in = s;
        step();
        load  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_tick();
        ena = 1'b1;
        step();
        ena = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [23:0] cnt,
                             input logic run_e, input logic done_e);
        chk({tag, " count"},   {hh, mm, ss}, cnt);
        chk({tag, " running"}, 24'(running), 24'(run_e));
        chk({tag, " done"},    24'(done),    24'(done_e));
    endtask

    initial begin
        step();
        step();
        chk_state("reset", 24'h000000, 1'b0, 1'b0);
        chk("reset load_err", 24'(load_err), 24'h0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        step();

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // 3-second countdown to DONE
        do_load(8'h00, 8'h00, 8'h03);
        chk_state("load3", 24'h000003, 1'b0, 1'b0);
        do_start();
        chk_state("start3", 24'h000003, 1'b1, 1'b0);
        do_tick();
        chk_state("tick 02", 24'h000002, 1'b1, 1'b0);
        do_tick();
        chk_state("tick 01", 24'h000001, 1'b1, 1'b0);
        do_tick();
        chk_state("tick 00", 24'h000000, 1'b0, 1'b1);
        step();
        chk("done drops", 24'(done), 24'h0);
        do_tick();
        chk_state("tick at zero", 24'h000000, 1'b0, 1'b0);

        // Borrow chains
        do_load(8'h01, 8'h00, 8'h00);
        do_start();
        do_tick();
        chk_state("01:00:00 tick", 24'h005959, 1'b1, 1'b0);
        do_load(8'h00, 8'h10, 8'h00);
        chk_state("load 00:10:00", 24'h001000, 1'b0, 1'b0);
        do_tick();
        chk("idle ignores ena", {hh, mm, ss}, 24'h001000);
        do_start();
        do_tick();
        chk("00:10:00 tick", {hh, mm, ss}, 24'h000959);
        do_load(8'h10, 8'h00, 8'h00);
        do_start();
        do_tick();
        chk("10:00:00 tick", {hh, mm, ss}, 24'h095959);

        // Invalid loads leave everything alone
        do_load(8'h00, 8'h00, 8'h60);
        chk("ss 60 load_err", 24'(load_err), 24'h1);
        chk_state("ss 60 unchanged", 24'h095959, 1'b1, 1'b0);
        step();
        chk("load_err one cycle", 24'(load_err), 24'h0);
        do_load(8'h13, 8'h00, 8'h00);
        chk("hh 13 load_err", 24'(load_err), 24'h1);
        chk("hh 13 unchanged", {hh, mm, ss}, 24'h095959);
        do_load(8'h0A, 8'h00, 8'h00);
        chk("hh nibble A load_err", 24'(load_err), 24'h1);
        do_load(8'h12, 8'h59, 8'h59);
        chk("hh 12 accepted", {hh, mm, ss}, 24'h125959);
        chk("hh 12 no err", 24'(load_err), 24'h0);

        // Pause/resume
        do_load(8'h00, 8'h00, 8'h05);
        do_start();
        do_tick();
        do_tick();
        do_stop();
        chk_state("paused", 24'h000003, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_tick();
        chk_state("paused ticks", 24'h000003, 1'b0, 1'b0);
        do_start();
        do_tick();
        chk_state("resumed", 24'h000002, 1'b1, 1'b0);

        // Same-cycle priorities
        stop = 1'b1;
        ena  = 1'b1;
        step();
        stop = 1'b0;
        ena  = 1'b0;
        chk_state("stop beats ena", 24'h000002, 1'b0, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("start beats stop", 24'(running), 24'h1);
        ena = 1'b1;
        do_load(8'h00, 8'h00, 8'h07);
        ena = 1'b0;
        chk_state("load beats ena", 24'h000007, 1'b0, 1'b0);
        start = 1'b1;
        do_load(8'h00, 8'h00, 8'h08);
        start = 1'b0;
        chk_state("load beats start", 24'h000008, 1'b0, 1'b0);

        // Start at zero goes straight to DONE
        do_load(8'h00, 8'h00, 8'h00);
        do_start();
        chk_state("start at zero", 24'h000000, 1'b0, 1'b1);
        step();
        chk("zero done drops", 24'(done), 24'h0);
        do_start();
        chk("start in DONE", 24'(done), 24'h0);

        // Asynchronous reset mid-count
        do_load(8'h00, 8'h00, 8'h41);
        do_start();
        do_tick();
        chk("at 00:00:40", {hh, mm, ss}, 24'h000040);
        #2;
        rst_b = 1'b0;
        #1;
        chk_state("async reset", 24'h000000, 1'b0, 1'b0);
        step();
        chk("no done in reset", 24'(done), 24'h0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        step();
        chk_state("after reset", 24'h000000, 1'b0, 1'b0);
`else
        // Auto-reload: zero-reaching tick pulses done and reloads in the same edge
        do_load(8'h00, 8'h00, 8'h02);
        do_start();
        do_tick();
        chk_state("ar tick 01", 24'h000001, 1'b1, 1'b0);
        do_tick();
        chk_state("ar reload", 24'h000002, 1'b1, 1'b1);
        do_tick();
        chk_state("ar tick 01 again", 24'h000001, 1'b1, 1'b0);
        do_stop();
        chk_state("ar stop", 24'h000001, 1'b0, 1'b0);
        do_start();
        do_tick();
        chk_state("ar second reload", 24'h000002, 1'b1, 1'b1);
        do_load(8'h00, 8'h00, 8'h00);
        do_start();
        chk_state("ar zero start", 24'h000000, 1'b0, 1'b1);
        do_load(8'h00, 8'h01, 8'h00);
        do_start();
        do_tick();
        chk_state("ar 00:00:59", 24'h000059, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
